// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial sequencer: accepts a word over valid/ready and streams it MSB-first, one bit per DIV clocks.
// Define SHIFT_SEQ_CTRL_PARITY_EN to append an even-parity bit after the data bits.
module shift_seq_ctrl #(
    parameter int WIDTH = 6,
    parameter int DIV   = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    input  logic                         abort,
    output logic                         ser_out,
    output logic                         ser_en,
    output logic [$clog2(WIDTH+1)-1:0]   bit_idx,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted
);
    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(WIDTH - 1);

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               ser_out_q, ser_out_d;
    logic               ser_en_q, ser_en_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    logic               parity_q, parity_d;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        aborted_d = 1'b0;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = S_SHIFT;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
                    parity_d  = ^in_data;
`endif
                end
            end
            S_SHIFT: begin
                // abort takes priority over the last-bit transition
                if (abort) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    aborted_d = 1'b1;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_DONE;
`endif
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
            S_PARITY: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    aborted_d = 1'b1;
                end else if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    state_d   = S_DONE;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight from flops
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        ser_en_d   = (state_d == S_SHIFT);
        ser_out_d  = ser_en_d & shreg_d[WIDTH-1];
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
        if (state_d == S_PARITY) begin
            ser_en_d  = 1'b1;
            ser_out_d = parity_d;
        end
`endif
        bit_idx_d  = ser_en_d ? bit_cnt_d : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            ser_out_q  <= 1'b0;
            ser_en_q   <= 1'b0;
            bit_idx_q  <= '0;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            ser_out_q  <= ser_out_d;
            ser_en_q   <= ser_en_d;
            bit_idx_q  <= bit_idx_d;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign ser_out  = ser_out_q;
    assign ser_en   = ser_en_q;
    assign bit_idx  = bit_idx_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: one DIV=1 instance and one DIV=3 instance sharing clock and reset.
module tb_shift_seq_ctrl;
    localparam int W  = 6;
    localparam int IW = $clog2(W + 1);
    localparam int D1 = 1;
    localparam int D3 = 3;
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int N1 = (W + PAR) * D1;
    localparam int N3 = (W + PAR) * D3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic          v1 = 1'b0, a1 = 1'b0;
    logic [W-1:0]  d1 = '0;
    logic          rdy1, so1, se1, busy1, done1, ab1;
    logic [IW-1:0] idx1;

    logic          v3 = 1'b0, a3 = 1'b0;
    logic [W-1:0]  d3 = '0;
    logic          rdy3, so3, se3, busy3, done3, ab3;
    logic [IW-1:0] idx3;

    logic [IW:0] q1[$];
    logic [IW:0] q3[$];
    logic [IW:0] e;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    shift_seq_ctrl #(.WIDTH(W), .DIV(D1)) dut1 (
        .clock(clock), .reset(reset), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
        .abort(a1), .ser_out(so1), .ser_en(se1), .bit_idx(idx1), .busy(busy1),
        .done(done1), .aborted(ab1)
    );

    shift_seq_ctrl #(.WIDTH(W), .DIV(D3)) dut3 (
        .clock(clock), .reset(reset), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .abort(a3), .ser_out(so3), .ser_en(se3), .bit_idx(idx3), .busy(busy3),
        .done(done3), .aborted(ab3)
    );

    // Expected serial stream: each bit repeated div times, MSB first, then optional parity.
    task automatic push_exp(input int sel, input logic [W-1:0] d, input int div);
        logic [IW:0] ent;
        for (int k = W - 1; k >= 0; k--) begin
            for (int r = 0; r < div; r++) begin
                ent = {d[k], IW'(W - 1 - k)};
                if (sel == 1) q1.push_back(ent); else q3.push_back(ent);
            end
        end
        if (PAR == 1) begin
            for (int r = 0; r < div; r++) begin
                ent = {^d, IW'(W)};
                if (sel == 1) q1.push_back(ent); else q3.push_back(ent);
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({rdy1, busy1, se1, so1, idx1, done1, ab1} !== {1'b1, 1'b0, 1'b0, 1'b0, IW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_dut1: got rdy/busy/en/out/idx/done/ab=%b %b %b %b %0d %b %b, want 1 0 0 0 0 0 0",
                     rdy1, busy1, se1, so1, idx1, done1, ab1);
        end
        checks++;
        if ({rdy3, busy3, se3, so3, idx3, done3, ab3} !== {1'b1, 1'b0, 1'b0, 1'b0, IW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_dut3: got rdy/busy/en/out/idx/done/ab=%b %b %b %b %0d %b %b, want 1 0 0 0 0 0 0",
                     rdy3, busy3, se3, so3, idx3, done3, ab3);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_basic();
        @(posedge clock);
        #1 v1 = 1'b1; d1 = 6'b101101;
        checks++;
        if (rdy1 !== 1'b1) begin errors++; $display("FAIL basic_ready_idle: got %b want 1", rdy1); end
        push_exp(1, d1, D1);
        @(posedge clock);
        #1 v1 = 1'b0;
        for (int c = 1; c <= N1 + 2; c++) begin
            @(negedge clock);
            if (c <= N1) begin
                checks++;
                if (se1 !== 1'b1) begin errors++; $display("FAIL basic_ser_en c=%0d: got %b want 1", c, se1); end
                checks++;
                if (q1.size() == 0) begin
                    errors++; $display("FAIL basic_sb c=%0d: unexpected bit %b idx %0d", c, so1, idx1);
                end else begin
                    e = q1.pop_front();
                    if ({so1, idx1} !== e) begin
                        errors++; $display("FAIL basic_bit c=%0d: got %b/%0d want %b/%0d", c, so1, idx1, e[IW], e[IW-1:0]);
                    end
                end
            end else if (c == N1 + 1) begin
                checks++;
                if ({done1, se1, rdy1} !== 3'b100) begin
                    errors++; $display("FAIL basic_done: got done/en/rdy=%b%b%b want 100", done1, se1, rdy1);
                end
            end else begin
                checks++;
                if ({rdy1, done1, busy1} !== 3'b100) begin
                    errors++; $display("FAIL basic_idle: got rdy/done/busy=%b%b%b want 100", rdy1, done1, busy1);
                end
            end
        end
    endtask

    task automatic test_clock_div();
        @(posedge clock);
        #1 v3 = 1'b1; d3 = 6'b110000;
        push_exp(3, d3, D3);
        @(posedge clock);
        #1 v3 = 1'b0;
        for (int c = 1; c <= N3 + 2; c++) begin
            @(negedge clock);
            if (c <= N3) begin
                checks++;
                if (q3.size() == 0 || se3 !== 1'b1) begin
                    errors++; $display("FAIL div_en c=%0d: got en=%b qsize=%0d want en=1", c, se3, q3.size());
                end else begin
                    e = q3.pop_front();
                    if ({so3, idx3} !== e) begin
                        errors++; $display("FAIL div_bit c=%0d: got %b/%0d want %b/%0d", c, so3, idx3, e[IW], e[IW-1:0]);
                    end
                end
            end else if (c == N3 + 1) begin
                checks++;
                if ({done3, se3} !== 2'b10) begin
                    errors++; $display("FAIL div_done: got done/en=%b%b want 10", done3, se3);
                end
            end else begin
                checks++;
                if ({rdy3, done3} !== 2'b10) begin
                    errors++; $display("FAIL div_idle: got rdy/done=%b%b want 10", rdy3, done3);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clock);
        #1 v1 = 1'b1; d1 = 6'b111001;
        push_exp(1, d1, D1);
        @(posedge clock);
        #1 d1 = 6'b010101;
        for (int c = 1; c <= N1 + 1; c++) begin
            @(negedge clock);
            checks++;
            if (rdy1 !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy c=%0d: got %b want 0", c, rdy1); end
            if (c <= N1) begin
                checks++;
                if (q1.size() == 0 || se1 !== 1'b1) begin
                    errors++; $display("FAIL b2b_first_en c=%0d: got en=%b want 1", c, se1);
                end else begin
                    e = q1.pop_front();
                    if ({so1, idx1} !== e) begin
                        errors++; $display("FAIL b2b_first_bit c=%0d: got %b/%0d want %b/%0d", c, so1, idx1, e[IW], e[IW-1:0]);
                    end
                end
            end else begin
                checks++;
                if (done1 !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done1); end
            end
        end
        @(negedge clock);
        checks++;
        if (rdy1 !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle: got %b want 1", rdy1); end
        push_exp(1, d1, D1);
        @(posedge clock);
        #1 v1 = 1'b0;
        for (int c = 1; c <= N1 + 1; c++) begin
            @(negedge clock);
            if (c <= N1) begin
                checks++;
                if (q1.size() == 0 || se1 !== 1'b1) begin
                    errors++; $display("FAIL b2b_second_en c=%0d: got en=%b want 1", c, se1);
                end else begin
                    e = q1.pop_front();
                    if ({so1, idx1} !== e) begin
                        errors++; $display("FAIL b2b_second_bit c=%0d: got %b/%0d want %b/%0d", c, so1, idx1, e[IW], e[IW-1:0]);
                    end
                end
            end else begin
                checks++;
                if (done1 !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b want 1", done1); end
            end
        end
        @(negedge clock);
    endtask

    task automatic test_abort();
        @(negedge clock);
        a1 = 1'b1;
        @(negedge clock);
        a1 = 1'b0;
        checks++;
        if ({ab1, rdy1, busy1} !== 3'b010) begin
            errors++; $display("FAIL abort_idle: got ab/rdy/busy=%b%b%b want 010", ab1, rdy1, busy1);
        end
        @(posedge clock);
        #1 v1 = 1'b1; d1 = 6'b111000;
        push_exp(1, d1, D1);
        @(posedge clock);
        #1 v1 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            checks++;
            if (q1.size() == 0 || se1 !== 1'b1) begin
                errors++; $display("FAIL abort_pre_en c=%0d: got en=%b want 1", c, se1);
            end else begin
                e = q1.pop_front();
                if ({so1, idx1} !== e) begin
                    errors++; $display("FAIL abort_pre_bit c=%0d: got %b/%0d want %b/%0d", c, so1, idx1, e[IW], e[IW-1:0]);
                end
            end
        end
        a1 = 1'b1;
        @(posedge clock);
        #1 a1 = 1'b0;
        q1.delete();
        @(negedge clock);
        checks++;
        if ({ab1, done1, se1, rdy1, busy1} !== 5'b10010) begin
            errors++; $display("FAIL abort_pulse: got ab/done/en/rdy/busy=%b%b%b%b%b want 10010", ab1, done1, se1, rdy1, busy1);
        end
        @(negedge clock);
        checks++;
        if ({ab1, done1} !== 2'b00) begin
            errors++; $display("FAIL abort_one_cycle: got ab/done=%b%b want 00", ab1, done1);
        end
        @(posedge clock);
        #1 v1 = 1'b1; d1 = 6'b001011;
        push_exp(1, d1, D1);
        @(posedge clock);
        #1 v1 = 1'b0;
        for (int c = 1; c <= N1 + 2; c++) begin
            @(negedge clock);
            if (c <= N1) begin
                checks++;
                if (q1.size() == 0 || se1 !== 1'b1) begin
                    errors++; $display("FAIL abort_next_en c=%0d: got en=%b want 1", c, se1);
                end else begin
                    e = q1.pop_front();
                    if ({so1, idx1} !== e) begin
                        errors++; $display("FAIL abort_next_bit c=%0d: got %b/%0d want %b/%0d", c, so1, idx1, e[IW], e[IW-1:0]);
                    end
                end
            end else if (c == N1 + 1) begin
                checks++;
                if ({done1, ab1} !== 2'b10) begin
                    errors++; $display("FAIL abort_next_done: got done/ab=%b%b want 10", done1, ab1);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clock);
        #1 v1 = 1'b1; d1 = 6'b101010;
        push_exp(1, d1, D1);
        @(posedge clock);
        #1 v1 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            checks++;
            if (q1.size() == 0 || se1 !== 1'b1) begin
                errors++; $display("FAIL arst_pre_en c=%0d: got en=%b want 1", c, se1);
            end else begin
                e = q1.pop_front();
                if ({so1, idx1} !== e) begin
                    errors++; $display("FAIL arst_pre_bit c=%0d: got %b/%0d want %b/%0d", c, so1, idx1, e[IW], e[IW-1:0]);
                end
            end
        end
        #2 reset = 1'b1;
        q1.delete();
        #1;
        checks++;
        if ({rdy1, busy1, se1, so1, idx1, done1, ab1} !== {1'b1, 1'b0, 1'b0, 1'b0, IW'(0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL arst_immediate: got rdy/busy/en/out/idx/done/ab=%b %b %b %b %0d %b %b, want 1 0 0 0 0 0 0",
                     rdy1, busy1, se1, so1, idx1, done1, ab1);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < N1 + 3; c++) begin
            @(negedge clock);
            checks++;
            if ({done1, se1, rdy1, ab1} !== 4'b0010) begin
                errors++; $display("FAIL arst_quiet c=%0d: got done/en/rdy/ab=%b%b%b%b want 0010", c, done1, se1, rdy1, ab1);
            end
        end
    endtask

`ifdef SHIFT_SEQ_CTRL_PARITY_EN
    task automatic test_parity();
        @(posedge clock);
        #1 v1 = 1'b1; d1 = 6'b100000;
        push_exp(1, d1, D1);
        @(posedge clock);
        #1 v1 = 1'b0;
        for (int c = 1; c <= N1 + 1; c++) begin
            @(negedge clock);
            if (c <= N1) begin
                checks++;
                if (q1.size() == 0 || se1 !== 1'b1) begin
                    errors++; $display("FAIL parity_en c=%0d: got en=%b want 1", c, se1);
                end else begin
                    e = q1.pop_front();
                    if ({so1, idx1} !== e) begin
                        errors++; $display("FAIL parity_bit c=%0d: got %b/%0d want %b/%0d", c, so1, idx1, e[IW], e[IW-1:0]);
                    end
                end
            end
            if (c == W + 1) begin
                checks++;
                if ({so1, idx1} !== {1'b1, IW'(W)}) begin
                    errors++; $display("FAIL parity_slot: got %b/%0d want 1/%0d", so1, idx1, W);
                end
            end
            if (c == N1 + 1) begin
                checks++;
                if (done1 !== 1'b1) begin errors++; $display("FAIL parity_done: got %b want 1", done1); end
            end
        end
        @(negedge clock);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_clock_div();
        test_back_to_back();
        test_abort();
        test_async_reset();
`ifdef SHIFT_SEQ_CTRL_PARITY_EN
        test_parity();
`endif
        checks++;
        if (q1.size() != 0 || q3.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d/%0d pending entries want 0/0", q1.size(), q3.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
